uart_rx_frame_check: RTL
========================

Name: uart_rx_frame_check

Overview:
- Parametrised successor to the single-mode UART RX parity checker.
- Consumes oversampled RX bits after start-bit validation: data bits, optional parity bit, 1 or 2 stop bits.
- Produces the parallel word, parity and stop errors, and saturating error statistics.
- Sits between the RX data sampler/edge counter and the RX FSM/bus interface; parity mode, data length and stop count are runtime-configurable.

Parameters:
- DATA_WIDTH, 8, maximum data bits per frame (legal 5..9).
- PRESCALE_WIDTH, 6, width of edge_cnt/prescale.
- ERR_CNT_WIDTH, 8, width of each saturating error counter.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- frame_start  in  1  one-cycle pulse: start bit validated; first data bit follows.
- sampled_bit  in  1  majority-voted bit value from the sampler.
- edge_cnt  in  PRESCALE_WIDTH  oversample edge counter, wraps at prescale-1.
- prescale  in  PRESCALE_WIDTH  oversample ratio (>=4).
- data_len  in  4  data bits per frame, 5..DATA_WIDTH.
- par_mode  in  3  0 none, 1 even, 2 odd, 3 mark, 4 space; 5-7 treated as none.
- stop_bits  in  1  0 = one stop bit, 1 = two.
- err_clr  in  1  synchronous clear of both error counters.
- p_data  out  DATA_WIDTH  received word, LSB-first, right-aligned, zero-extended.
- frame_done  out  1  one-cycle pulse at end of frame.
- par_err  out  1  parity error of the last frame.
- stp_err  out  1  stop error of the last frame.
- busy  out  1  high from frame_start until frame_done.
- par_err_cnt  out  ERR_CNT_WIDTH  saturating parity error count.
- stp_err_cnt  out  ERR_CNT_WIDTH  saturating stop error count.

Behaviour:
- Reset: all outputs 0; FSM in IDLE; internal bit index 0.
- Bit strobe: edge_cnt == prescale-1 while in DATA, PARITY or STOP. sampled_bit is consumed in that cycle.
- States and transitions:
  - IDLE -> DATA on frame_start.
  - DATA -> PARITY after data_len strobes if par_mode is 1-4; otherwise DATA -> STOP.
  - PARITY -> STOP after 1 strobe.
  - STOP -> DONE after 1 strobe (stop_bits=0) or 2 strobes (stop_bits=1).
  - DONE -> IDLE unconditionally, next cycle.
- Configuration: data_len, par_mode and stop_bits are latched at frame_start; changes mid-frame are ignored.
- data_len outside 5..DATA_WIDTH is clamped to DATA_WIDTH.
- Data capture: p_data[idx] <= sampled_bit, idx 0..data_len-1. At frame_start, p_data is cleared and idx reset to 0.
- Running parity: XOR of the data bits, updated on each DATA strobe.
- Parity check at the PARITY strobe:
  - even: error if running ^ bit = 1.
  - odd: error if running ^ bit = 0.
  - mark: error if bit = 0.
  - space: error if bit = 1.
  - none: par_err = 0.
- stp_err = 1 if any checked stop bit samples 0.
- Latency and output timing:
  - frame_done is asserted in the cycle after the last stop strobe (DONE state).
  - p_data, par_err and stp_err are updated in that same cycle and held until the next frame_start, which clears par_err/stp_err.
- Counters:
  - Incremented in the DONE cycle when the corresponding error is set.
  - Saturate at all-ones with no wrap.
  - err_clr in the same cycle as an increment: the clear wins.
- frame_start while busy: the current frame is aborted and restarted; no frame_done and no counter update for the aborted frame.
- Async reset mid-frame: immediate return to IDLE, outputs 0.

Optional Feature:
- Macro UART_RX_BREAK_DETECT_EN.
- When defined:
  - Adds output brk_det (1 bit), pulsed with frame_done when every data bit, the parity bit (if present) and all stop bits sampled 0.
  - On break, stp_err and par_err are forced to 0 and counters are not incremented.
- When undefined: the port is absent and all-zero frames are reported as ordinary stop/parity errors.

Decomposition:
- Package uart_rx_pkg:
  - par_mode encodings (PAR_NONE, PAR_EVEN, PAR_ODD, PAR_MARK, PAR_SPACE).
  - FSM state encoding (IDLE, DATA, PARITY, STOP, DONE).
  - Legal data_len bounds.
- Sub-module uart_sat_counter (parameter WIDTH; inputs inc, clr with clr priority), instantiated twice.

Test Plan:
- Even parity: prescale=8, data_len=8, par_mode=1, stop_bits=0, data 0xB2, parity bit 0, stop 1 -> frame_done one cycle after the stop strobe, p_data=0xB2, par_err=0, stp_err=0. Repeat with parity bit 1 -> par_err=1, par_err_cnt=1.
- Odd/mark/space: data 0xB2, parity bit 1:
  - odd -> par_err=0.
  - mark -> par_err=0.
  - space -> par_err=1.
- Short word: data_len=7, par_mode=0, bits 1,0,1,0,1,0,1 -> p_data=0x55 after exactly 8 strobes (7 data + 1 stop).
- Two stop bits: stop_bits=1, first stop 1, second stop 0 -> stp_err=1, stp_err_cnt increments by 1.
- Abort: frame_start reasserted after 3 data strobes, then a clean 0x3C frame -> exactly one frame_done, p_data=0x3C, counters unchanged.
- Saturation and clear: ERR_CNT_WIDTH=2, five parity-error frames -> par_err_cnt=3. err_clr coincident with the 6th error's DONE cycle -> par_err_cnt=0.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared encodings for the UART RX frame checker.
// This file holds the parity modes, FSM states, data length bounds and the frame configuration latch.
package uart_rx_pkg;

    localparam logic [2:0] PAR_NONE  = 3'd0;
    localparam logic [2:0] PAR_EVEN  = 3'd1;
    localparam logic [2:0] PAR_ODD   = 3'd2;
    localparam logic [2:0] PAR_MARK  = 3'd3;
    localparam logic [2:0] PAR_SPACE = 3'd4;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_DATA   = 3'd1;
    localparam logic [2:0] ST_PARITY = 3'd2;
    localparam logic [2:0] ST_STOP   = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    localparam logic [3:0] DATA_LEN_MIN = 4'd5;
    localparam logic [3:0] DATA_LEN_MAX = 4'd9;

    typedef struct packed {
        logic [3:0] len;
        logic [2:0] par;
        logic       stop2;
    } rx_cfg_t;

    // An illegal length falls back to the widest word, and an unknown parity mode falls back to none.
    function automatic rx_cfg_t latch_cfg(logic [3:0] len, logic [2:0] par, logic stop2,
                                          logic [3:0] max_len);
        rx_cfg_t c;
        c.len   = (len < DATA_LEN_MIN || len > max_len) ? max_len : len;
        c.par   = (par > PAR_SPACE) ? PAR_NONE : par;
        c.stop2 = stop2;
        return c;
    endfunction

endpackage

// File: rtl/uart_rx_frame_check_if.sv
// uart_rx_frame_check_if: bundle between the RX sampler and the frame checker.
// The brk_det signal exists only when UART_RX_BREAK_DETECT_EN is defined.
interface uart_rx_frame_check_if #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6,
    parameter int ERR_CNT_WIDTH  = 8
);
    logic                      frame_start;
    logic                      sampled_bit;
    logic [PRESCALE_WIDTH-1:0] edge_cnt;
    logic [PRESCALE_WIDTH-1:0] prescale;
    logic [3:0]                data_len;
    logic [2:0]                par_mode;
    logic                      stop_bits;
    logic                      err_clr;
    logic [DATA_WIDTH-1:0]     p_data;
    logic                      frame_done;
    logic                      par_err;
    logic                      stp_err;
    logic                      busy;
    logic [ERR_CNT_WIDTH-1:0]  par_err_cnt;
    logic [ERR_CNT_WIDTH-1:0]  stp_err_cnt;
`ifdef UART_RX_BREAK_DETECT_EN
    logic                      brk_det;
`endif

    modport master (
        output frame_start, sampled_bit, edge_cnt, prescale, data_len, par_mode, stop_bits, err_clr,
`ifdef UART_RX_BREAK_DETECT_EN
        input  brk_det,
`endif
        input  p_data, frame_done, par_err, stp_err, busy, par_err_cnt, stp_err_cnt
    );

    modport slave (
        input  frame_start, sampled_bit, edge_cnt, prescale, data_len, par_mode, stop_bits, err_clr,
`ifdef UART_RX_BREAK_DETECT_EN
        output brk_det,
`endif
        output p_data, frame_done, par_err, stp_err, busy, par_err_cnt, stp_err_cnt
    );

endinterface

// File: rtl/uart_sat_counter.sv
// uart_sat_counter: saturating event counter, where a clear takes priority over an increment.
module uart_sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] cnt_o
);

    logic [WIDTH-1:0] cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            cnt_q <= '0;
        else if (clr_i)
            cnt_q <= '0;
        else if (inc_i && cnt_q != '1)
            cnt_q <= cnt_q + WIDTH'(1);
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/uart_rx_frame_check.sv
// uart_rx_frame_check: receives the data, parity and stop bits of a frame and reports errors and statistics.
// Defining UART_RX_BREAK_DETECT_EN adds brk_det, which reports all-zero frames as a break instead of as errors.
module uart_rx_frame_check
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6,
    parameter int ERR_CNT_WIDTH  = 8
) (
    input logic                 clk,
    input logic                 reset_n,
    uart_rx_frame_check_if.slave bus
);

    localparam int LEN_MAX = (DATA_WIDTH < int'(DATA_LEN_MAX)) ? DATA_WIDTH : int'(DATA_LEN_MAX);

    logic [2:0]            state_q, state_d;
    rx_cfg_t               cfg_q;
    logic [3:0]            idx_q;
    logic [DATA_WIDTH-1:0] p_data_q;
    logic                  par_acc_q, par_bad_q, stp_bad_q, stop_idx_q;
    logic                  par_err_q, stp_err_q;
    logic                  strobe, last_data, last_stop, stop_end, par_bit_bad, stp_bad, done, brk;

    assign strobe    = (state_q == ST_DATA || state_q == ST_PARITY || state_q == ST_STOP) &&
                       bus.edge_cnt == bus.prescale - PRESCALE_WIDTH'(1);
    assign last_data = idx_q == cfg_q.len - 4'd1;
    assign last_stop = stop_idx_q == cfg_q.stop2;
    assign stop_end  = strobe && state_q == ST_STOP && last_stop;
    assign stp_bad   = stp_bad_q | ~bus.sampled_bit;
    assign done      = state_q == ST_DONE;

    always_comb begin
        par_bit_bad = (cfg_q.par == PAR_EVEN)  ? (par_acc_q ^ bus.sampled_bit) :
                      (cfg_q.par == PAR_ODD)   ? ~(par_acc_q ^ bus.sampled_bit) :
                      (cfg_q.par == PAR_MARK)  ? ~bus.sampled_bit :
                      (cfg_q.par == PAR_SPACE) ? bus.sampled_bit : 1'b0;
    end

    // A new frame_start takes priority in every state, which is how an in-flight frame is aborted.
    always_comb begin
        state_d = state_q;
        if (bus.frame_start)
            state_d = ST_DATA;
        else if (done)
            state_d = ST_IDLE;
        else if (strobe)
            state_d = (state_q == ST_DATA)   ? (!last_data ? ST_DATA :
                                                (cfg_q.par != PAR_NONE) ? ST_PARITY : ST_STOP) :
                      (state_q == ST_PARITY) ? ST_STOP :
                      last_stop              ? ST_DONE : ST_STOP;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            cfg_q      <= '0;
            idx_q      <= '0;
            p_data_q   <= '0;
            par_acc_q  <= 1'b0;
            par_bad_q  <= 1'b0;
            stp_bad_q  <= 1'b0;
            stop_idx_q <= 1'b0;
            par_err_q  <= 1'b0;
            stp_err_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (bus.frame_start) begin
                cfg_q      <= latch_cfg(bus.data_len, bus.par_mode, bus.stop_bits, 4'(LEN_MAX));
                idx_q      <= '0;
                p_data_q   <= '0;
                par_acc_q  <= 1'b0;
                par_bad_q  <= 1'b0;
                stp_bad_q  <= 1'b0;
                stop_idx_q <= 1'b0;
                par_err_q  <= 1'b0;
                stp_err_q  <= 1'b0;
            end else if (strobe) begin
                if (state_q == ST_DATA) begin
                    p_data_q  <= p_data_q | (DATA_WIDTH'(bus.sampled_bit) << idx_q);
                    idx_q     <= idx_q + 4'd1;
                    par_acc_q <= par_acc_q ^ bus.sampled_bit;
                end
                if (state_q == ST_PARITY)
                    par_bad_q <= par_bit_bad;
                if (state_q == ST_STOP) begin
                    stop_idx_q <= 1'b1;
                    stp_bad_q  <= stp_bad;
                end
                // Error flags become visible in DONE, so they are loaded together with the last stop strobe.
                if (stop_end) begin
                    par_err_q <= par_bad_q & ~brk;
                    stp_err_q <= stp_bad & ~brk;
                end
            end
        end
    end

`ifdef UART_RX_BREAK_DETECT_EN
    logic zero_q, brk_q;

    assign brk = zero_q & ~bus.sampled_bit;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            zero_q <= 1'b0;
            brk_q  <= 1'b0;
        end else if (bus.frame_start) begin
            zero_q <= 1'b1;
            brk_q  <= 1'b0;
        end else if (strobe) begin
            zero_q <= zero_q & ~bus.sampled_bit;
            if (stop_end)
                brk_q <= brk;
        end
    end

    assign bus.brk_det = done & brk_q;
`else
    assign brk = 1'b0;
`endif

    assign bus.p_data     = p_data_q;
    assign bus.frame_done = done;
    assign bus.par_err    = par_err_q;
    assign bus.stp_err    = stp_err_q;
    assign bus.busy       = state_q != ST_IDLE && !done;

    uart_sat_counter #(.WIDTH(ERR_CNT_WIDTH)) u_par_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clr_i   (bus.err_clr),
        .inc_i   (done & par_err_q),
        .cnt_o   (bus.par_err_cnt)
    );

    uart_sat_counter #(.WIDTH(ERR_CNT_WIDTH)) u_stp_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clr_i   (bus.err_clr),
        .inc_i   (done & stp_err_q),
        .cnt_o   (bus.stp_err_cnt)
    );

endmodule
